// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central sequencer for the PC and the four pipeline registers
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). Produces per-stage enable/flush from
//   cache handshakes, load-use hazards, taken branches and halt. Holds the
//   whole pipeline while a data-memory access is outstanding and remembers
//   an instruction hit that arrives during that hold.
//
// Optional build macro: HAZARD_PERF_CNT_EN
//   Adds CNT_W-bit saturating counters stall_cycles / flush_events.
//
// Ports
//   CLK, nRST          clock (rising edge), async active-low reset
//   ihit, dhit         icache / dcache completion this cycle
//   dmem_req           EX/MEM holds a data-memory access
//   idex_memread       ID/EX holds a load, destination idex_rw
//   ifid_rs/rt         source registers of the IF/ID instruction
//   ifid_uses_rt       IF/ID instruction reads rt
//   branch_taken       PC redirect resolved in EX
//   halt_in            halt opcode at MEM/WB output
//   pc_en, *_en        PC / stage register enables
//   *_flush            stage bubble insert (wins over enable)
//   halt_out           registered halted indication
//   stall_cycles       (macro only) cycles with pc_en=0 while running
//   flush_events       (macro only) taken-branch flushes
module pipeline_hazard_ctrl #(
   parameter int unsigned REGW = 5
`ifdef HAZARD_PERF_CNT_EN
  ,parameter int unsigned CNT_W = 32
`endif
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            ihit,
   input  logic            dhit,
   input  logic            dmem_req,
   input  logic            idex_memread,
   input  logic [REGW-1:0] idex_rw,
   input  logic [REGW-1:0] ifid_rs,
   input  logic [REGW-1:0] ifid_rt,
   input  logic            ifid_uses_rt,
   input  logic            branch_taken,
   input  logic            halt_in,
   output logic            pc_en,
   output logic            ifid_en,
   output logic            idex_en,
   output logic            exmem_en,
   output logic            memwb_en,
   output logic            ifid_flush,
   output logic            idex_flush,
   output logic            exmem_flush,
   output logic            memwb_flush,
   output logic            halt_out
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
`endif
);

   typedef enum logic [1:0] {INIT, RUN, DWAIT, HALTED} state_t;

   state_t state, state_n;
   logic   ihit_seen, ihit_seen_n;
   logic   dstall, lu_hazard, fetch_ok, running;

   assign running   = (state == RUN) || (state == DWAIT);
   assign dstall    = dmem_req & ~dhit;
   assign fetch_ok  = ihit | ihit_seen;
   assign lu_hazard = idex_memread && (idex_rw != '0) &&
                      ((idex_rw == ifid_rs) || (ifid_uses_rt && (idex_rw == ifid_rt)));

   // state register
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state     <= INIT;
         ihit_seen <= 1'b0;
         halt_out  <= 1'b0;
      end else begin
         state     <= state_n;
         ihit_seen <= ihit_seen_n;
         halt_out  <= (state_n == HALTED);
      end
   end

   // next-state logic
   always_comb begin
      state_n     = state;
      ihit_seen_n = ihit_seen;
      case (state)
         INIT:   state_n = RUN;
         RUN,
         DWAIT: begin
            if (dstall) begin
               // hold everything; a hit arriving now must not be lost
               state_n = DWAIT;
               if (ihit) ihit_seen_n = 1'b1;
            end else begin
               ihit_seen_n = 1'b0;
               state_n     = halt_in ? HALTED : RUN;
            end
         end
         HALTED: state_n = HALTED;
         default: state_n = INIT;
      endcase
   end

   // stage control outputs; flushed stages keep their enable low
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      if (nRST) begin
         if (state == INIT) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
         end else if (running && !dstall) begin
            if (branch_taken) begin
               pc_en      = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
            end else if (lu_hazard) begin
               idex_flush = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
            end else if (!fetch_ok) begin
               ifid_flush = 1'b1;
               idex_en    = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
            end else begin
               pc_en    = 1'b1;
               ifid_en  = 1'b1;
               idex_en  = 1'b1;
               exmem_en = 1'b1;
               memwb_en = 1'b1;
            end
            if (halt_in) memwb_en = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else if (running) begin
         if (!pc_en && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
         if (!dstall && branch_taken && (flush_events != '1))
            flush_events <= flush_events + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit, dmem_req, idex_memread, ifid_uses_rt, branch_taken, halt_in;
   logic [4:0] idex_rw, ifid_rs, ifid_rt;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_out;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_events;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   pipeline_hazard_ctrl #(.REGW(5)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
      .idex_memread(idex_memread), .idex_rw(idex_rw), .ifid_rs(ifid_rs),
      .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken),
      .halt_in(halt_in), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .halt_out(halt_out)
`ifdef HAZARD_PERF_CNT_EN
     ,.stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic       ihit, dhit, dmem_req, idex_memread;
      logic [4:0] idex_rw, ifid_rs, ifid_rt;
      logic       ifid_uses_rt, branch_taken, halt_in;
   } in_t;

   typedef struct {
      in_t         in;
      logic [9:0]  exp;   // {halt_out, pc_en, 4 x en, 4 x flush}
      string       name;
   } vec_t;

   // {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
   localparam logic [8:0] P_ZERO = 9'b0_0000_0000;
   localparam logic [8:0] P_INIT = 9'b0_0000_1111;
   localparam logic [8:0] P_BR   = 9'b1_0011_1100;
   localparam logic [8:0] P_LU   = 9'b0_0011_0100;
   localparam logic [8:0] P_FS   = 9'b0_0111_1000;
   localparam logic [8:0] P_NORM = 9'b1_1111_0000;

   // reference model state
   int          m_st;      // 0 init, 1 run, 2 data wait, 3 halted
   bit          m_seen;
   logic [31:0] m_stall, m_flush;

   function automatic in_t mk(int ih, int dh, int dr, int mr, int rw, int rs, int rt,
                              int urt, int br, int hl);
      in_t v;
      v.ihit = 1'(ih); v.dhit = 1'(dh); v.dmem_req = 1'(dr); v.idex_memread = 1'(mr);
      v.idex_rw = 5'(rw); v.ifid_rs = 5'(rs); v.ifid_rt = 5'(rt);
      v.ifid_uses_rt = 1'(urt); v.branch_taken = 1'(br); v.halt_in = 1'(hl);
      return v;
   endfunction

   task automatic drive(input in_t v);
      ihit = v.ihit; dhit = v.dhit; dmem_req = v.dmem_req; idex_memread = v.idex_memread;
      idex_rw = v.idex_rw; ifid_rs = v.ifid_rs; ifid_rt = v.ifid_rt;
      ifid_uses_rt = v.ifid_uses_rt; branch_taken = v.branch_taken; halt_in = v.halt_in;
   endtask

   function automatic logic [9:0] outs();
      return {halt_out, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, memwb_flush};
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (halt,pc,en[4],flush[4])", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected outputs derived from the rule priorities, chosen as a whole pattern.
   function automatic logic [9:0] model_out(input in_t v);
      bit ds, lu, fok;
      logic [8:0] p;
      ds  = v.dmem_req && !v.dhit;
      lu  = v.idex_memread && (v.idex_rw != 0) &&
            ((v.idex_rw == v.ifid_rs) || (v.ifid_uses_rt && (v.idex_rw == v.ifid_rt)));
      fok = v.ihit || m_seen;
      if (m_st == 0)           p = P_INIT;
      else if (m_st == 3)      p = P_ZERO;
      else if (ds)             p = P_ZERO;
      else if (v.branch_taken) p = P_BR;
      else if (lu)             p = P_LU;
      else if (!fok)           p = P_FS;
      else                     p = P_NORM;
      return {(m_st == 3), p};
   endfunction

   task automatic model_step(input in_t v, input logic pc);
      bit ds;
      ds = v.dmem_req && !v.dhit;
      if (m_st == 0) m_st = 1;
      else if (m_st == 1 || m_st == 2) begin
         if (!pc && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (!ds && v.branch_taken && m_flush != 32'hFFFF_FFFF) m_flush++;
         if (ds) begin
            m_st = 2;
            if (v.ihit) m_seen = 1;
         end else begin
            m_seen = 0;
            m_st = v.halt_in ? 3 : 1;
         end
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the next one with nRST released.
   task automatic reset_pulse(input string name);
      nRST = 1'b0;
      #1;
      check({name, "_in_reset"}, outs(), 10'b0);
`ifdef HAZARD_PERF_CNT_EN
      check32({name, "_stall_rst"}, stall_cycles, 0);
      check32({name, "_flush_rst"}, flush_events, 0);
`endif
      m_st = 0; m_seen = 0; m_stall = 0; m_flush = 0;
      @(posedge CLK); #1;
      nRST = 1'b1;
   endtask

   task automatic step_fixed(input in_t v, input logic [9:0] exp, input string name);
      drive(v);
      @(negedge CLK);
      check(name, outs(), exp);
      @(posedge CLK); #1;
   endtask

   function automatic in_t rand_in();
      in_t v;
      v.ihit         = ($urandom_range(0, 3) != 0);
      v.dhit         = $urandom_range(0, 1) == 1;
      v.dmem_req     = ($urandom_range(0, 2) == 0);
      v.idex_memread = ($urandom_range(0, 2) == 0);
      v.idex_rw      = 5'($urandom_range(0, 3));
      v.ifid_rs      = 5'($urandom_range(0, 3));
      v.ifid_rt      = 5'($urandom_range(0, 3));
      v.ifid_uses_rt = $urandom_range(0, 1) == 1;
      v.branch_taken = ($urandom_range(0, 5) == 0);
      v.halt_in      = ($urandom_range(0, 59) == 0);
      return v;
   endfunction

   vec_t tbl[18];

   initial begin
      in_t  v;
      logic [9:0] e;

      tbl[0]  = '{mk(1,0,0,0,0,0,0,0,0,0), {1'b0, P_INIT}, "init_flush"};
      tbl[1]  = '{mk(1,0,0,0,0,0,0,0,0,0), {1'b0, P_NORM}, "first_run"};
      tbl[2]  = '{mk(1,0,0,1,8,8,1,0,0,0), {1'b0, P_LU},   "loaduse_rs"};
      tbl[3]  = '{mk(1,0,0,1,0,0,0,1,0,0), {1'b0, P_NORM}, "loaduse_r0"};
      tbl[4]  = '{mk(1,0,0,1,8,3,8,1,0,0), {1'b0, P_LU},   "loaduse_rt"};
      tbl[5]  = '{mk(1,0,0,1,8,3,8,0,0,0), {1'b0, P_NORM}, "rt_not_used"};
      tbl[6]  = '{mk(0,0,0,0,0,0,0,0,0,0), {1'b0, P_FS},   "fetch_stall"};
      tbl[7]  = '{mk(0,0,0,0,0,0,0,0,1,0), {1'b0, P_BR},   "branch_nohit"};
      tbl[8]  = '{mk(0,0,0,1,8,8,0,0,1,0), {1'b0, P_BR},   "branch_over_lu"};
      tbl[9]  = '{mk(1,1,1,0,0,0,0,0,0,0), {1'b0, P_NORM}, "dreq_dhit_same"};
      tbl[10] = '{mk(0,0,1,0,0,0,0,0,0,0), {1'b0, P_ZERO}, "dstall_1"};
      tbl[11] = '{mk(1,0,1,0,0,0,0,0,1,0), {1'b0, P_ZERO}, "dstall_2_ihit"};
      tbl[12] = '{mk(0,0,1,1,8,8,0,0,0,0), {1'b0, P_ZERO}, "dstall_3"};
      tbl[13] = '{mk(0,1,1,0,0,0,0,0,0,0), {1'b0, P_NORM}, "dwait_release"};
      tbl[14] = '{mk(0,0,0,0,0,0,0,0,0,0), {1'b0, P_FS},   "seen_cleared"};
      tbl[15] = '{mk(1,0,0,0,0,0,0,0,0,1), {1'b0, P_NORM}, "halt_cycle"};
      tbl[16] = '{mk(1,0,0,0,0,0,0,0,1,0), {1'b1, P_ZERO}, "halted_br"};
      tbl[17] = '{mk(1,0,1,1,8,8,0,0,1,1), {1'b1, P_ZERO}, "halted_any"};

      nRST = 1'b0;
      drive(mk(1,0,0,0,0,0,0,0,0,0));
      repeat (2) @(posedge CLK);
      #1;
      check("reset_state", outs(), 10'b0);
      @(posedge CLK); #1;
      nRST = 1'b1;

      for (int i = 0; i < 18; i++) step_fixed(tbl[i].in, tbl[i].exp, tbl[i].name);

      // reset while halted returns to INIT with halt_out cleared
      reset_pulse("halt_reset");
      step_fixed(mk(1,0,0,0,0,0,0,0,0,0), {1'b0, P_INIT}, "post_halt_init");
      step_fixed(mk(1,0,0,0,0,0,0,0,0,0), {1'b0, P_NORM}, "post_halt_run");

      // reset in the middle of a data wait discards the captured hit
      step_fixed(mk(1,0,1,0,0,0,0,0,0,0), {1'b0, P_ZERO}, "mid_dstall");
      reset_pulse("dwait_reset");
      step_fixed(mk(0,0,0,0,0,0,0,0,0,0), {1'b0, P_INIT}, "dwait_reset_init");
      step_fixed(mk(0,0,0,0,0,0,0,0,0,0), {1'b0, P_FS},   "no_stale_hit");

`ifdef HAZARD_PERF_CNT_EN
      reset_pulse("perf_reset");
      step_fixed(mk(1,0,0,0,0,0,0,0,0,0), {1'b0, P_INIT}, "perf_init");
      for (int i = 0; i < 3; i++)
         step_fixed(mk(1,0,0,1,8,8,0,0,0,0), {1'b0, P_LU}, "perf_lu");
      for (int i = 0; i < 2; i++)
         step_fixed(mk(1,0,0,0,0,0,0,0,1,0), {1'b0, P_BR}, "perf_br");
      drive(mk(1,0,0,0,0,0,0,0,0,0));
      @(negedge CLK);
      check32("perf_stall_cycles", stall_cycles, 3);
      check32("perf_flush_events", flush_events, 2);
      @(posedge CLK); #1;
`endif

      // randomized run against the reference model
      reset_pulse("rand_reset");
      for (int c = 0; c < 1500; c++) begin
         if ((m_st == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
            reset_pulse("rand_midreset");
         v = rand_in();
         drive(v);
         @(negedge CLK);
         e = model_out(v);
         check("rand", outs(), e);
`ifdef HAZARD_PERF_CNT_EN
         check32("rand_stall_cycles", stall_cycles, m_stall);
         check32("rand_flush_events", flush_events, m_flush);
`endif
         model_step(v, e[8]);
         @(posedge CLK); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
